spi_master_cmd_sequencer: RTL and testbench

//  Command sequencer directly upstream of the FCB SPI master serializer/deserializer.
//  - Accepts a queued stream of byte-level SPI commands (write byte, read byte, stop, stop+ext-clock) from the FCB register/bus side.
//  - Drives the start/stop/read/write level handshake of the serializer and captures its read bytes into a read FIFO.
//  - Lets software issue multi-byte SPI transactions without per-byte interrupt servicing.

---
 rtl/spi_master_cmd_sequencer_pkg.sv | 39 +++
 rtl/spi_master_cmd_sequencer_fifo.sv | 63 ++++++
 rtl/spi_master_cmd_sequencer.sv | 171 +++++++++++++++++
 tb/tb_spi_master_cmd_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_cmd_sequencer_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : spi_master_cmd_sequencer_pkg                                    |
// | Purpose  : Opcodes, command field offsets and FSM encoding for the         |
// |            SPI master command sequencer.                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package spi_master_cmd_sequencer_pkg;

  localparam logic [1:0] c_OP_WR       = 2'd0;
  localparam logic [1:0] c_OP_RD       = 2'd1;
  localparam logic [1:0] c_OP_STOP     = 2'd2;
  localparam logic [1:0] c_OP_STOP_EXT = 2'd3;

  localparam int c_CMD_W    = 10;
  localparam int c_OP_MSB   = 9;
  localparam int c_OP_LSB   = 8;
  localparam int c_BYTE_MSB = 7;
  localparam int c_BYTE_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_XFER      = 3'd2,
    ST_ACK_WAIT  = 3'd3,
    ST_STOP_REQ  = 3'd4,
    ST_STOP_WAIT = 3'd5,
    ST_ERR       = 3'd6
  } seq_state_t;

  // STOP_EXT behaves like STOP here; the extended clock is owned by the register block.
  function automatic logic is_data_op(input logic [1:0] op);
    return !(op == c_OP_STOP || op == c_OP_STOP_EXT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_master_cmd_sequencer_fifo.sv
// +----------------------------------------------------------------------------+
// | Module   : spi_seq_fifo                                                    |
// | Purpose  : First-word-fall-through FIFO with separate occupancy counter.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     Bus_CLK_i,
  input  logic                     RST_i,
  input  logic                     RST_SYNC_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int                c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]     c_FULL = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (level_o == '0);
  assign w_full    = (level_o == c_FULL);
  assign w_do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is accepted only when a legal pop frees the slot.
  assign w_do_push = push_i && (!w_full || w_do_pop);
  assign dout_o    = empty_o ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge Bus_CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      level_o  <= '0;
    end else if (RST_SYNC_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      level_o  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      level_o <= level_o + 1'b1;
      else if (w_do_pop && !w_do_push) level_o <= level_o - 1'b1;
    end
  end

  always_ff @(posedge Bus_CLK_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/spi_master_cmd_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module   : spi_master_cmd_sequencer                                        |
// | Purpose  : Queues byte-level SPI commands and drives the serializer        |
// |            start/stop/read/write handshake, capturing read bytes.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_master_cmd_sequencer
  import spi_master_cmd_sequencer_pkg::*;
#(
  parameter int CMD_DEPTH = 16,
  parameter int RD_DEPTH  = 16,
  parameter int TMO_W     = 16
) (
  input  logic                         Bus_CLK_i,
  input  logic                         RST_i,
  input  logic                         RST_SYNC_i,
  input  logic                         cmd_wr_i,
  input  logic [c_CMD_W-1:0]           cmd_data_i,
  output logic                         cmd_full_o,
  output logic [$clog2(CMD_DEPTH):0]   cmd_level_o,
  input  logic                         rd_pop_i,
  output logic [7:0]                   rd_data_o,
  output logic                         rd_empty_o,
  output logic                         busy_o,
  output logic                         done_irq_o,
  output logic                         err_ovf_o,
  output logic                         err_tmo_o,
  input  logic                         err_clr_i,
  output logic                         start_o,
  output logic                         stop_o,
  output logic                         write_o,
  output logic                         read_o,
  output logic [7:0]                   wdata_o,
  input  logic                         irq_write_i,
  input  logic                         irq_read_i,
  input  logic                         xfer_cmplte_i,
  input  logic [7:0]                   rdata_i
);

  localparam int                    c_CMD_LW    = $clog2(CMD_DEPTH) + 1;
  localparam int                    c_RD_LW     = $clog2(RD_DEPTH) + 1;
  localparam logic [c_CMD_LW-1:0]   c_CMD_FULL  = c_CMD_LW'(CMD_DEPTH);
  localparam logic [c_RD_LW-1:0]    c_RD_FULL   = c_RD_LW'(RD_DEPTH);
  localparam logic [TMO_W-1:0]      c_WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  seq_state_t          r_state;
  logic [1:0]          r_op;
  logic [TMO_W-1:0]    r_wdog;
  logic [c_CMD_W-1:0]  w_cmd_head;
  logic [1:0]          w_cmd_op;
  logic [7:0]          w_cmd_byte;
  logic                w_cmd_empty;
  logic                w_cmd_flush;
  logic [c_RD_LW-1:0]  w_rd_level;
  logic                w_rd_push;
  logic                w_rd_ovf;
  logic                w_wait_st;
  logic                w_advance;
  logic                w_timeout;

  assign w_cmd_op    = w_cmd_head[c_OP_MSB:c_OP_LSB];
  assign w_cmd_byte  = w_cmd_head[c_BYTE_MSB:c_BYTE_LSB];
  assign w_cmd_flush = RST_SYNC_i || (r_state == ST_ERR);
  assign cmd_full_o  = (cmd_level_o == c_CMD_FULL);
  assign busy_o      = (r_state != ST_IDLE) || !w_cmd_empty;

  assign w_rd_push = (r_state == ST_XFER) && (r_op == c_OP_RD) && irq_read_i;
  // A capture into a full FIFO still lands if software pops in the same cycle.
  assign w_rd_ovf  = w_rd_push && (w_rd_level == c_RD_FULL) && !rd_pop_i;

  assign w_wait_st = (r_state == ST_XFER) || (r_state == ST_ACK_WAIT) ||
                     (r_state == ST_STOP_REQ) || (r_state == ST_STOP_WAIT);
  assign w_timeout = w_wait_st && !w_advance && (r_wdog == c_WDOG_LAST);

  always_comb begin
    w_advance = 1'b0;
    case (r_state)
      ST_XFER:      w_advance = (r_op == c_OP_RD) ? irq_read_i : irq_write_i;
      ST_ACK_WAIT:  w_advance = !irq_write_i && !irq_read_i;
      ST_STOP_REQ:  w_advance = xfer_cmplte_i;
      ST_STOP_WAIT: w_advance = !xfer_cmplte_i;
      default:      w_advance = 1'b0;
    endcase
  end

  spi_seq_fifo #(.WIDTH(c_CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .Bus_CLK_i  (Bus_CLK_i),
    .RST_i      (RST_i),
    .RST_SYNC_i (w_cmd_flush),
    .push_i     (cmd_wr_i),
    .pop_i      (r_state == ST_FETCH),
    .din_i      (cmd_data_i),
    .dout_o     (w_cmd_head),
    .empty_o    (w_cmd_empty),
    .level_o    (cmd_level_o)
  );

  spi_seq_fifo #(.WIDTH(8), .DEPTH(RD_DEPTH)) u_rd_fifo (
    .Bus_CLK_i  (Bus_CLK_i),
    .RST_i      (RST_i),
    .RST_SYNC_i (RST_SYNC_i),
    .push_i     (w_rd_push),
    .pop_i      (rd_pop_i),
    .din_i      (rdata_i),
    .dout_o     (rd_data_o),
    .empty_o    (rd_empty_o),
    .level_o    (w_rd_level)
  );

  always_ff @(posedge Bus_CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_state <= ST_IDLE;  r_op <= c_OP_WR;  r_wdog <= '0;
      start_o <= 1'b0;  stop_o <= 1'b0;  write_o <= 1'b0;  read_o <= 1'b0;
      wdata_o <= '0;  done_irq_o <= 1'b0;  err_ovf_o <= 1'b0;  err_tmo_o <= 1'b0;
    end else if (RST_SYNC_i) begin
      r_state <= ST_IDLE;  r_op <= c_OP_WR;  r_wdog <= '0;
      start_o <= 1'b0;  stop_o <= 1'b0;  write_o <= 1'b0;  read_o <= 1'b0;
      wdata_o <= '0;  done_irq_o <= 1'b0;  err_ovf_o <= 1'b0;  err_tmo_o <= 1'b0;
    end else begin
      done_irq_o <= 1'b0;
      r_wdog     <= (w_wait_st && !w_advance) ? r_wdog + 1'b1 : '0;
      // Clear wins; an error raised in the clearing cycle is lost.
      if (err_clr_i)     err_ovf_o <= 1'b0;
      else if (w_rd_ovf) err_ovf_o <= 1'b1;
      if (err_clr_i)     err_tmo_o <= 1'b0;

      if (w_timeout) begin
        r_state <= ST_ERR;  r_wdog <= '0;
        start_o <= 1'b0;  stop_o <= 1'b0;  write_o <= 1'b0;  read_o <= 1'b0;
        wdata_o <= '0;
        if (!err_clr_i) err_tmo_o <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: if (!w_cmd_empty) r_state <= ST_FETCH;
          ST_FETCH: begin
            r_op    <= w_cmd_op;
            wdata_o <= w_cmd_byte;
            if (is_data_op(w_cmd_op)) begin
              r_state <= ST_XFER;
              start_o <= 1'b1;
              write_o <= (w_cmd_op == c_OP_WR);
              read_o  <= (w_cmd_op == c_OP_RD);
            end else begin
              r_state <= ST_STOP_REQ;
              stop_o  <= 1'b1;
            end
          end
          ST_XFER: if (w_advance) begin
            r_state <= ST_ACK_WAIT;
            start_o <= 1'b0;  write_o <= 1'b0;  read_o <= 1'b0;
          end
          ST_STOP_REQ: if (w_advance) begin
            r_state <= ST_STOP_WAIT;
            stop_o  <= 1'b0;
          end
          ST_ACK_WAIT, ST_STOP_WAIT: if (w_advance) begin
            r_state    <= ST_IDLE;
            done_irq_o <= w_cmd_empty && !cmd_wr_i;
          end
          ST_ERR: if (err_clr_i) r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_cmd_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_spi_master_cmd_sequencer                                     |
// | Purpose  : Scoreboard bench with a behavioural serializer model.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_spi_master_cmd_sequencer;
  import spi_master_cmd_sequencer_pkg::*;

  logic       Bus_CLK_i = 1'b0;
  logic       RST_i = 1'b1, RST_SYNC_i = 1'b0;
  logic       cmd_wr_i = 1'b0, rd_pop_i = 1'b0, err_clr_i = 1'b0;
  logic [9:0] cmd_data_i = '0;
  logic       irq_write_i, irq_read_i, xfer_cmplte_i;
  logic [7:0] rdata_i;
  logic       cmd_full_o, rd_empty_o, busy_o, done_irq_o, err_ovf_o, err_tmo_o;
  logic       start_o, stop_o, write_o, read_o;
  logic [4:0] cmd_level_o;
  logic [7:0] rd_data_o, wdata_o;

  spi_master_cmd_sequencer #(.CMD_DEPTH(16), .RD_DEPTH(16), .TMO_W(4)) dut (
    .Bus_CLK_i(Bus_CLK_i), .RST_i(RST_i), .RST_SYNC_i(RST_SYNC_i),
    .cmd_wr_i(cmd_wr_i), .cmd_data_i(cmd_data_i), .cmd_full_o(cmd_full_o),
    .cmd_level_o(cmd_level_o), .rd_pop_i(rd_pop_i), .rd_data_o(rd_data_o),
    .rd_empty_o(rd_empty_o), .busy_o(busy_o), .done_irq_o(done_irq_o),
    .err_ovf_o(err_ovf_o), .err_tmo_o(err_tmo_o), .err_clr_i(err_clr_i),
    .start_o(start_o), .stop_o(stop_o), .write_o(write_o), .read_o(read_o),
    .wdata_o(wdata_o), .irq_write_i(irq_write_i), .irq_read_i(irq_read_i),
    .xfer_cmplte_i(xfer_cmplte_i), .rdata_i(rdata_i)
  );

  always #5 Bus_CLK_i = ~Bus_CLK_i;

  int         n_chk = 0, n_pass = 0;
  int         done_cnt = 0, stop_cnt = 0;
  logic [7:0] exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] mdl_rq[$];
  int         mdl_delay = 3, mdl_hold = 1;
  bit         mdl_dead = 1'b0, mdl_rd;
  bit         prev_wr = 1'b0, prev_stop = 1'b0;
  logic [7:0] held_byte = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Serializer model: irq after mdl_delay edges, held for mdl_hold edges.
  initial begin
    irq_write_i = 1'b0; irq_read_i = 1'b0; xfer_cmplte_i = 1'b0; rdata_i = '0;
    forever begin
      @(posedge Bus_CLK_i); #1;
      if (start_o && !mdl_dead) begin
        mdl_rd = read_o;
        repeat (mdl_delay) @(posedge Bus_CLK_i);
        #1;
        if (start_o) begin
          if (mdl_rd) begin
            rdata_i = (mdl_rq.size() > 0) ? mdl_rq.pop_front() : 8'h00;
            irq_read_i = 1'b1;
          end else irq_write_i = 1'b1;
          repeat (mdl_hold) @(posedge Bus_CLK_i);
          #1; irq_read_i = 1'b0; irq_write_i = 1'b0;
        end
      end else if (stop_o && !mdl_dead) begin
        repeat (2) @(posedge Bus_CLK_i);
        #1;
        if (stop_o) begin
          xfer_cmplte_i = 1'b1;
          @(posedge Bus_CLK_i); #1; xfer_cmplte_i = 1'b0;
        end
      end
    end
  end

  // Monitor: compares presented write bytes and popped read bytes against the queues.
  initial begin
    forever begin
      @(negedge Bus_CLK_i);
      if (RST_i) continue;
      if (done_irq_o) done_cnt++;
      if (stop_o && !prev_stop) stop_cnt++;
      prev_stop = stop_o;
      if (start_o && write_o && !prev_wr) begin
        held_byte = wdata_o;
        if (exp_wr.size() == 0) check("wr_unexpected", {24'h0, wdata_o}, 32'hFFFF_FFFF);
        else check("wr_byte", {24'h0, wdata_o}, {24'h0, exp_wr.pop_front()});
      end else if (start_o && write_o && wdata_o !== held_byte)
        check("wdata_hold", {24'h0, wdata_o}, {24'h0, held_byte});
      prev_wr = start_o && write_o;
      if (rd_pop_i && !rd_empty_o) begin
        if (exp_rd.size() == 0) check("rd_unexpected", {24'h0, rd_data_o}, 32'hFFFF_FFFF);
        else check("rd_byte", {24'h0, rd_data_o}, {24'h0, exp_rd.pop_front()});
      end
      if (start_o && stop_o) check("start_stop_excl", 1, 0);
      if (read_o && write_o) check("read_write_excl", 1, 0);
    end
  end

  task automatic push(input logic [1:0] op, input logic [7:0] b);
    cmd_data_i = {op, b}; cmd_wr_i = 1'b1;
    @(posedge Bus_CLK_i); #1;
    cmd_wr_i = 1'b0;
  endtask

  task automatic pop_rd();
    rd_pop_i = 1'b1;
    @(posedge Bus_CLK_i); #1;
    rd_pop_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 2000) begin @(posedge Bus_CLK_i); #1; n++; end
    check(name, busy_o, 0);
    repeat (2) @(posedge Bus_CLK_i);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int d0, s0, n;
    repeat (3) @(posedge Bus_CLK_i);
    #1;
    check("rst_outs", {start_o, stop_o, write_o, read_o, busy_o, done_irq_o,
                       err_ovf_o, err_tmo_o, cmd_full_o, |wdata_o, |rd_data_o}, 0);
    check("rst_level", cmd_level_o, 0);
    check("rst_rd_empty", rd_empty_o, 1);
    RST_i = 1'b0;
    @(posedge Bus_CLK_i); #1;

    // 1: single write then stop
    d0 = done_cnt; s0 = stop_cnt;
    exp_wr.push_back(8'hA5);
    push(c_OP_WR, 8'hA5);
    push(c_OP_STOP, 8'h00);
    wait_idle("t1_idle");
    check("t1_done", done_cnt - d0, 1);
    check("t1_stop", stop_cnt - s0, 1);
    check("t1_wr_seen", exp_wr.size(), 0);

    // 2: write then three reads
    d0 = done_cnt;
    exp_wr.push_back(8'h9F);
    mdl_rq = '{8'h11, 8'h22, 8'h33};
    exp_rd = '{8'h11, 8'h22, 8'h33};
    push(c_OP_WR, 8'h9F);
    for (int i = 0; i < 3; i++) push(c_OP_RD, 8'h00);
    push(c_OP_STOP_EXT, 8'h00);
    wait_idle("t2_idle");
    check("t2_done", done_cnt - d0, 1);
    check("t2_rd_not_empty", rd_empty_o, 0);
    for (int i = 0; i < 3; i++) pop_rd();
    check("t2_rd_empty", rd_empty_o, 1);
    check("t2_rd_seen", exp_rd.size(), 0);

    // 3: command FIFO fills while a slow transfer blocks the FSM
    d0 = done_cnt;
    mdl_delay = 10; mdl_hold = 10;
    exp_wr.push_back(8'h3C);
    push(c_OP_WR, 8'h3C);
    n = 0;
    while (!start_o && n < 20) begin @(posedge Bus_CLK_i); #1; n++; end
    check("t3_blocker", start_o, 1);
    for (int i = 0; i < 15; i++) push(c_OP_STOP, 8'h00);
    check("t3_not_full", cmd_full_o, 0);
    push(c_OP_STOP, 8'h00);
    check("t3_full", cmd_full_o, 1);
    check("t3_level16", cmd_level_o, 16);
    push(c_OP_WR, 8'hEE);
    check("t3_level_after17", cmd_level_o, 16);
    mdl_delay = 3; mdl_hold = 1;
    wait_idle("t3_idle");
    check("t3_done", done_cnt - d0, 1);

    // 4: read FIFO overflow
    d0 = done_cnt;
    for (int i = 0; i < 17; i++) mdl_rq.push_back(8'h40 + 8'(i));
    for (int i = 0; i < 16; i++) exp_rd.push_back(8'h40 + 8'(i));
    for (int i = 0; i < 17; i++) push(c_OP_RD, 8'h00);
    push(c_OP_STOP, 8'h00);
    wait_idle("t4_idle");
    check("t4_ovf", err_ovf_o, 1);
    check("t4_done", done_cnt - d0, 1);
    for (int i = 0; i < 16; i++) pop_rd();
    check("t4_rd_empty", rd_empty_o, 1);
    check("t4_rd_seen", exp_rd.size(), 0);
    err_clr_i = 1'b1; @(posedge Bus_CLK_i); #1; err_clr_i = 1'b0;
    check("t4_ovf_clr", err_ovf_o, 0);

    // 5: handshake timeout
    d0 = done_cnt;
    mdl_dead = 1'b1;
    exp_wr.push_back(8'h5A);
    push(c_OP_WR, 8'h5A);
    push(c_OP_WR, 8'h77);
    n = 0;
    while (!start_o && n < 50) begin @(posedge Bus_CLK_i); #1; n++; end
    check("t5_start", start_o, 1);
    n = 0;
    while (!err_tmo_o && n < 40) begin @(posedge Bus_CLK_i); #1; n++; end
    check("t5_tmo_cycles", n, 15);
    check("t5_outs_zero", {start_o, stop_o, write_o, read_o, wdata_o}, 0);
    @(posedge Bus_CLK_i); #1;
    check("t5_cmd_flushed", cmd_level_o, 0);
    check("t5_busy_err", busy_o, 1);
    mdl_dead = 1'b0;
    err_clr_i = 1'b1; @(posedge Bus_CLK_i); #1; err_clr_i = 1'b0;
    check("t5_tmo_clr", err_tmo_o, 0);
    repeat (3) @(posedge Bus_CLK_i);
    #1;
    check("t5_idle_after_clr", busy_o, 0);
    check("t5_no_done", done_cnt - d0, 0);

    // 6: synchronous clear mid-read
    d0 = done_cnt;
    mdl_delay = 6;
    push(c_OP_RD, 8'h00);
    push(c_OP_STOP, 8'h00);
    n = 0;
    while (!(start_o && read_o) && n < 50) begin @(posedge Bus_CLK_i); #1; n++; end
    check("t6_in_xfer", start_o && read_o, 1);
    RST_SYNC_i = 1'b1;
    @(posedge Bus_CLK_i); #1;
    RST_SYNC_i = 1'b0;
    check("t6_drop", {start_o, read_o}, 0);
    check("t6_cmd_empty", cmd_level_o, 0);
    repeat (10) @(posedge Bus_CLK_i);
    #1;
    check("t6_rd_empty", rd_empty_o, 1);
    check("t6_idle", busy_o, 0);
    check("t6_no_done", done_cnt - d0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
